// File: rtl/key_pulse_bank_if.sv
// key_pulse_bank_if: key inputs, trigger selects and conditioned outputs of the key pulse bank.
// The master side drives the keys; the slave side is the conditioner.
interface key_pulse_bank_if #(
    parameter int unsigned N = 4
);
    logic [N-1:0] key;
    logic [N-1:0] edge_sel;
    logic [N-1:0] out;
    logic [N-1:0] held;
    logic         any_out;

    modport master (
        output key,
        output edge_sel,
        input  out,
        input  held,
        input  any_out
    );

    modport slave (
        input  key,
        input  edge_sel,
        output out,
        output held,
        output any_out
    );
endinterface

// File: rtl/key_pulse_bank.sv
// key_pulse_bank: per-channel synchroniser, debouncer and one-shot pulse generator.
// Optional auto-repeat for press-triggered channels is compiled in when KEY_PULSE_REPEAT_EN
// is defined; without it each qualified press or release yields exactly one pulse.
module key_pulse_bank #(
    parameter int unsigned N               = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_PERIOD   = 3
) (
    input logic              clk,
    input logic              reset,
    key_pulse_bank_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time sanity guard: every timing parameter must be at least one cycle.
    if (N < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        bad_key_pulse_bank_parameters u_bad_cfg ();
    end

    logic [N-1:0]     sync1_q, sync2_q;
    logic [N-1:0]     held_q, held_d;
    logic [N-1:0]     out_q, out_d;
    logic             any_q;
    logic [N-1:0]     flip;
    logic [N-1:0]     edge_pulse;
    logic [N-1:0]     rep_pulse;
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];

    // Debounce: count consecutive disagreeing cycles, flip the level on the last one.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            flip[i]  = 1'b0;
            cnt_d[i] = '0;
            if (sync2_q[i] != held_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    flip[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            // Rising flip (held 0 -> 1) qualifies when edge_sel is 1, falling when it is 0.
            edge_pulse[i] = flip[i] & (bus.edge_sel[i] ? ~held_q[i] : held_q[i]);
        end
        held_d = held_q ^ flip;
    end

`ifdef KEY_PULSE_REPEAT_EN
    localparam int unsigned REP_MAX =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W = $clog2(REP_MAX + 1);

    // rep_q counts cycles since the last pulse of the train; zero means no train running.
    logic [REP_W-1:0] rep_q [N];
    logic [REP_W-1:0] rep_d [N];
    logic [N-1:0]     rep_first_q, rep_first_d;

    // Repeat train: start on a press pulse, fire after DELAY then every PERIOD while held.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            rep_d[i]       = rep_q[i];
            rep_first_d[i] = rep_first_q[i];
            rep_pulse[i]   = 1'b0;
            if (flip[i] && !held_q[i] && bus.edge_sel[i]) begin
                rep_d[i]       = REP_W'(1);
                rep_first_d[i] = 1'b1;
            end else if (!bus.edge_sel[i] || !held_q[i] || flip[i]) begin
                // Release or mode change ends the train with no extra pulse.
                rep_d[i]       = '0;
                rep_first_d[i] = 1'b0;
            end else if (rep_q[i] != '0) begin
                if (rep_q[i] == (rep_first_q[i] ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_PERIOD)))
                begin
                    rep_pulse[i]   = 1'b1;
                    rep_d[i]       = REP_W'(1);
                    rep_first_d[i] = 1'b0;
                end else begin
                    rep_d[i] = rep_q[i] + 1'b1;
                end
            end
        end
    end

    // Repeat counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                rep_q[i] <= '0;
            end
            rep_first_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                rep_q[i] <= rep_d[i];
            end
            rep_first_q <= rep_first_d;
        end
    end
`else
    assign rep_pulse = '0;
`endif

    assign out_d = edge_pulse | rep_pulse;

    // Synchroniser, debounce state and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            held_q  <= '0;
            out_q   <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= bus.key;
            sync2_q <= sync1_q;
            held_q  <= held_d;
            out_q   <= out_d;
            any_q   <= |out_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.out     = out_q;
    assign bus.held    = held_q;
    assign bus.any_out = any_q;
endmodule

// File: tb/tb_key_pulse_bank.sv
// tb_key_pulse_bank: directed table-driven bench for key_pulse_bank (N=2, DEBOUNCE_CYCLES=4),
// plus hand-written reset and auto-repeat sequences.
module tb_key_pulse_bank;
    localparam int unsigned N = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    key_pulse_bank_if #(.N(N)) bus ();

    key_pulse_bank #(
        .N               (N),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] key;
        logic [1:0] sel;
        int         ticks;
        logic [1:0] exp_out;
        logic [1:0] exp_held;
        logic       exp_any;
    } vec_t;

    vec_t vecs [22];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Ticks until out[0] is seen high, bounded; returns the tick count (limit+1 if never seen).
    task automatic wait_pulse0(output int n);
        n = 0;
        while (n <= 20) begin
            tick(1);
            n++;
            if (bus.out[0]) break;
        end
    endtask

    initial begin
        int n;
        logic exp_rep;

        // A level change set just after edge e is sampled at e+1; held/out flip on the 6th tick.
        vecs[0]  = '{2'b01, 2'b11, 5, 2'b00, 2'b00, 1'b0};
        vecs[1]  = '{2'b01, 2'b11, 1, 2'b01, 2'b01, 1'b1};
        vecs[2]  = '{2'b01, 2'b11, 1, 2'b00, 2'b01, 1'b0};
        vecs[3]  = '{2'b00, 2'b11, 5, 2'b00, 2'b01, 1'b0};
        vecs[4]  = '{2'b00, 2'b11, 1, 2'b00, 2'b00, 1'b0};
        // Release-triggered channel 0.
        vecs[5]  = '{2'b01, 2'b10, 5, 2'b00, 2'b00, 1'b0};
        vecs[6]  = '{2'b01, 2'b10, 1, 2'b00, 2'b01, 1'b0};
        vecs[7]  = '{2'b01, 2'b10, 4, 2'b00, 2'b01, 1'b0};
        vecs[8]  = '{2'b00, 2'b10, 5, 2'b00, 2'b01, 1'b0};
        vecs[9]  = '{2'b00, 2'b10, 1, 2'b01, 2'b00, 1'b1};
        vecs[10] = '{2'b00, 2'b10, 1, 2'b00, 2'b00, 1'b0};
        // Glitch train: high 3, low 2, high 3, then low.
        vecs[11] = '{2'b01, 2'b11, 3, 2'b00, 2'b00, 1'b0};
        vecs[12] = '{2'b00, 2'b11, 2, 2'b00, 2'b00, 1'b0};
        vecs[13] = '{2'b01, 2'b11, 3, 2'b00, 2'b00, 1'b0};
        vecs[14] = '{2'b00, 2'b11, 8, 2'b00, 2'b00, 1'b0};
        // Both keys together, then edge_sel change alone, then release in release mode.
        vecs[15] = '{2'b11, 2'b11, 5, 2'b00, 2'b00, 1'b0};
        vecs[16] = '{2'b11, 2'b11, 1, 2'b11, 2'b11, 1'b1};
        vecs[17] = '{2'b11, 2'b11, 1, 2'b00, 2'b11, 1'b0};
        vecs[18] = '{2'b11, 2'b00, 2, 2'b00, 2'b11, 1'b0};
        vecs[19] = '{2'b00, 2'b00, 5, 2'b00, 2'b11, 1'b0};
        vecs[20] = '{2'b00, 2'b00, 1, 2'b11, 2'b00, 1'b1};
        vecs[21] = '{2'b00, 2'b00, 1, 2'b00, 2'b00, 1'b0};

        reset        = 1'b1;
        bus.key      = '0;
        bus.edge_sel = 2'b11;
        tick(2);
        check("reset out", bus.out, 2'b00);
        check("reset held", bus.held, 2'b00);
        check("reset any_out", bus.any_out, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            bus.key      = vecs[i].key;
            bus.edge_sel = vecs[i].sel;
            tick(vecs[i].ticks);
            check($sformatf("vec%0d out", i), bus.out, vecs[i].exp_out);
            check($sformatf("vec%0d held", i), bus.held, vecs[i].exp_held);
            check($sformatf("vec%0d any_out", i), bus.any_out, vecs[i].exp_any);
        end

        // Reset in the middle of a held press: outputs clear, then a fresh press pulse.
        bus.key      = 2'b01;
        bus.edge_sel = 2'b11;
        wait_pulse0(n);
        check("pre-reset press latency", n, 6);
        tick(1);
        check("pre-reset pulse width", bus.out, 2'b00);
        tick(1);
        reset = 1'b1;
        tick(1);
        check("in reset out", bus.out, 2'b00);
        check("in reset held", bus.held, 2'b00);
        tick(1);
        check("in reset any_out", bus.any_out, 1'b0);
        check("in reset held 2", bus.held, 2'b00);
        reset = 1'b0;
        wait_pulse0(n);
        check("post-reset press latency", n, 6);
        check("post-reset held", bus.held, 2'b01);
        tick(1);
        check("post-reset pulse width", bus.out, 2'b00);

        // Release, then a long press-mode hold for the repeat train.
        bus.key = 2'b00;
        tick(8);
        check("released held", bus.held, 2'b00);
        bus.edge_sel = 2'b01;
        bus.key      = 2'b01;
        wait_pulse0(n);
        check("repeat press latency", n, 6);
        for (int k = 1; k <= 30; k++) begin
            if (k == 16) bus.key = 2'b00;
            tick(1);
`ifdef KEY_PULSE_REPEAT_EN
            exp_rep = (k >= 8 && k <= 20 && ((k - 8) % 3) == 0);
`else
            exp_rep = 1'b0;
`endif
            check($sformatf("repeat P+%0d out", k), bus.out, {1'b0, exp_rep});
        end
        check("repeat end held", bus.held, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
